// File: rtl/detect_event_logger_pkg.sv
// -----------------------------------------------------------------------------
// detect_event_pkg
// Shared constants and helpers for the detection event logger.
//   CNT_W_DEF / DEPTH_DEF / TOT_W_DEF : default parameter values
//   lvl_w()   : width of a 0..DEPTH occupancy count
//   sat_inc() : increment that holds at the all-ones value of a w-bit field
// -----------------------------------------------------------------------------
package detect_event_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned TOT_W_DEF = 16;

  // Occupancy must represent DEPTH itself, hence one bit more than the address.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Saturating increment of a w-bit value carried in 32 bits (w < 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max;
    max = (32'd1 << w) - 32'd1;
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/detect_event_logger_fifo.sv
// -----------------------------------------------------------------------------
// detect_event_fifo
// Show-ahead FIFO: head_o presents the oldest entry while not empty, 0 when empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
//   clk_i, rst_i (async, active-high), clr_i (sync empty)
//   push_i/data_i : write request and data
//   pop_i         : remove head entry (ignored while empty)
//   head_o, full_o, empty_o, level_o (0..DEPTH)
// -----------------------------------------------------------------------------
module detect_event_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o = (lvl_q == '0);
    full_o  = (lvl_q == LVL_W'(DEPTH));
    pop_ok  = pop_i && !empty_o;
    // A simultaneous pop frees the slot this push needs.
    push_ok = push_i && (!full_o || pop_ok);
    lvl_d   = lvl_q;
    if (push_ok && !pop_ok)      lvl_d = lvl_q + 1'b1;
    else if (pop_ok && !push_ok) lvl_d = lvl_q - 1'b1;
    head_o  = empty_o ? '0 : mem_q[rd_q];
    level_o = lvl_q;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: contents are only visible through the level count.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/detect_event_logger.sv
// -----------------------------------------------------------------------------
// detect_event_logger
// Edge-detects the sequence detector's output, measures the cycle interval
// between detections and queues intervals in a show-ahead FIFO.
//   clk, rst (async, active-high), clr (sync clear of counters/FIFO/flags)
//   det_in                : detector level output
//   evt_valid/evt_ready   : FIFO read handshake, evt_interval = head entry
//   total_cnt             : saturating count of all detections (incl. dropped)
//   overflow              : sticky, set when a detection is dropped (FIFO full)
//   fifo_level            : occupancy 0..DEPTH
//   drop_cnt              : only with DETECT_EVENT_LOGGER_DROP_COUNT_EN defined;
//                           saturating count of dropped detections
// -----------------------------------------------------------------------------
module detect_event_logger
  import detect_event_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TOT_W = TOT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      det_in,
  input  logic                      clr,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [CNT_W-1:0]          evt_interval,
  output logic [TOT_W-1:0]          total_cnt,
  output logic                      overflow,
  output logic [lvl_w(DEPTH)-1:0]   fifo_level
`ifdef DETECT_EVENT_LOGGER_DROP_COUNT_EN
  ,
  output logic [7:0]                drop_cnt
`endif
);

  localparam int unsigned LVL_W = lvl_w(DEPTH);

  logic             d1_q, d2_q, rise;
  logic [CNT_W-1:0] ivl_q, ivl_d, ivl_inc;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, drop, full, empty;

  always_comb begin
    rise    = d1_q & ~d2_q;
    ivl_inc = CNT_W'(sat_inc(32'(ivl_q), CNT_W));
    pop     = ~empty & evt_ready & ~clr;
    push    = rise & ~clr;
    drop    = push & full & ~pop;
    ivl_d   = ivl_inc;
    tot_d   = tot_q;
    ovf_d   = ovf_q;
    if (clr) begin
      ivl_d = '0;
      tot_d = '0;
      ovf_d = 1'b0;
    end else if (rise) begin
      ivl_d = '0;
      tot_d = TOT_W'(sat_inc(32'(tot_q), TOT_W));
      if (drop) ovf_d = 1'b1;
    end
  end

  // d1/d2 keep sampling through clr so a level already high is not re-detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q  <= 1'b0;
      d2_q  <= 1'b0;
      ivl_q <= '0;
      tot_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      d1_q  <= det_in;
      d2_q  <= d1_q;
      ivl_q <= ivl_d;
      tot_q <= tot_d;
      ovf_q <= ovf_d;
    end
  end

  detect_event_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (clr),
    .push_i  (push),
    .data_i  (ivl_inc),
    .pop_i   (pop),
    .head_o  (evt_interval),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_comb begin
    evt_valid = ~empty;
    total_cnt = tot_q;
    overflow  = ovf_q;
  end

`ifdef DETECT_EVENT_LOGGER_DROP_COUNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       drop_q <= '0;
    else if (clr)  drop_q <= '0;
    else if (drop) drop_q <= 8'(sat_inc(32'(drop_q), 8));
  end

  always_comb drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_detect_event_logger.sv
module tb_detect_event_logger;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic        clk = 1'b0;
  logic        rst, det_in, clr, evt_ready;
  logic        evt_valid, overflow;
  logic [7:0]  evt_interval;
  logic [15:0] total_cnt;
  logic [LW-1:0] fifo_level;
`ifdef DETECT_EVENT_LOGGER_DROP_COUNT_EN
  logic [7:0]  drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: cycle counts between detections, a queue of intervals.
  int q[$];
  int since, m_total, m_drops;
  bit m_ovf, s1, s2;

  always #5 clk = ~clk;

  detect_event_logger #(.CNT_W(8), .DEPTH(DEPTH), .TOT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .det_in       (det_in),
    .clr          (clr),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_interval (evt_interval),
    .total_cnt    (total_cnt),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
`ifdef DETECT_EVENT_LOGGER_DROP_COUNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  task automatic model_reset;
    q.delete();
    since = 0; m_total = 0; m_drops = 0;
    m_ovf = 0; s1 = 0; s2 = 0;
  endtask

  // One clock edge: a detection is a 0->1 change of the sampled det_in,
  // acted on one edge after it is sampled.
  task automatic model_edge(input bit d, input bit r, input bit c);
    bit rise;
    rise = s1 && !s2;
    since++;
    if (c) begin
      q.delete();
      since = 0; m_total = 0; m_drops = 0; m_ovf = 0;
    end else begin
      if (r && q.size() > 0) void'(q.pop_front());
      if (rise) begin
        if (m_total < 65535) m_total++;
        if (q.size() < DEPTH) q.push_back(since > 255 ? 255 : since);
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
        since = 0;
      end
    end
    s2 = s1;
    s1 = d;
  endtask

  task automatic step(input bit d, input bit r, input bit c);
    det_in = d; evt_ready = r; clr = c;
    @(posedge clk);
    model_edge(d, r, c);
    #1;
  endtask

  task automatic apply_reset;
    det_in = 0; evt_ready = 0; clr = 0;
    @(posedge clk); #1;
    rst = 1;
    #3;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset;
    rst = 1; det_in = 0; clr = 0; evt_ready = 0;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_interval !== 8'd0 || fifo_level !== '0 ||
        total_cnt !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: valid=%b ivl=%0d lvl=%0d tot=%0d ovf=%b expected all 0",
               evt_valid, evt_interval, fifo_level, total_cnt, overflow);
    end
    #10; rst = 0; model_reset();
    for (int i = 0; i < 3; i++) begin step(1, 0, 0); step(0, 0, 0); end
    checks++;
    if (fifo_level !== LW'(3)) begin
      errors++; $display("FAIL reset_prefill: level=%0d expected 3", fifo_level);
    end
    #2; rst = 1; #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_interval !== 8'd0 || fifo_level !== '0 ||
        total_cnt !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b ivl=%0d lvl=%0d tot=%0d ovf=%b expected all 0",
               evt_valid, evt_interval, fifo_level, total_cnt, overflow);
    end
    #2; rst = 0; model_reset();
  endtask

  task automatic test_single_pulse;
    apply_reset();
    repeat (9) step(0, 0, 0);
    step(1, 0, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: valid=%b expected 0", evt_valid);
    end
    step(0, 0, 0);
    checks++;
    if (evt_valid !== 1'b1 || evt_interval !== 8'd11 || total_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_pulse: valid=%b ivl=%0d tot=%0d expected 1/11/1",
               evt_valid, evt_interval, total_cnt);
    end
  endtask

  task automatic test_held_level;
    apply_reset();
    repeat (20) step(1, 0, 0);
    checks++;
    if (total_cnt !== 16'd1 || fifo_level !== LW'(1)) begin
      errors++;
      $display("FAIL held_level: tot=%0d lvl=%0d expected 1/1", total_cnt, fifo_level);
    end
  endtask

  task automatic test_periodic;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      step((i % 2) == 0, 1, 0);
      checks++;
      if (fifo_level > LW'(1) || (evt_valid === 1'b1 && evt_interval !== 8'd2)) begin
        errors++;
        $display("FAIL periodic[%0d]: lvl=%0d ivl=%0d expected lvl<=1 ivl=2",
                 i, fifo_level, evt_interval);
      end
    end
  endtask

  task automatic test_full;
    int gaps[6];
    int expv[4];
    apply_reset();
    for (int p = 0; p < 6; p++) begin
      gaps[p] = $urandom_range(1, 5);
      step(1, 0, 0);
      repeat (gaps[p]) step(0, 0, 0);
    end
    expv[0] = 2;
    for (int i = 1; i < 4; i++) expv[i] = gaps[i-1] + 1;
    checks++;
    if (fifo_level !== LW'(4) || overflow !== 1'b1 || total_cnt !== 16'd6) begin
      errors++;
      $display("FAIL full_state: lvl=%0d ovf=%b tot=%0d expected 4/1/6",
               fifo_level, overflow, total_cnt);
    end
`ifdef DETECT_EVENT_LOGGER_DROP_COUNT_EN
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++; $display("FAIL full_drop_cnt: got %0d expected 2", drop_cnt);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_interval !== 8'(expv[i])) begin
        errors++;
        $display("FAIL full_pop[%0d]: valid=%b ivl=%0d expected 1/%0d",
                 i, evt_valid, evt_interval, expv[i]);
      end
      step(0, 1, 0);
    end
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_drained: valid=%b ovf=%b expected 0/1", evt_valid, overflow);
    end
  endtask

  task automatic test_full_simultaneous;
    int expv[4] = '{2, 2, 2, 4};
    apply_reset();
    for (int p = 0; p < 4; p++) begin step(1, 0, 0); step(0, 0, 0); end
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    checks++;
    if (fifo_level !== LW'(4) || overflow !== 1'b0 || total_cnt !== 16'd5) begin
      errors++;
      $display("FAIL simul_state: lvl=%0d ovf=%b tot=%0d expected 4/0/5",
               fifo_level, overflow, total_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_interval !== 8'(expv[i])) begin
        errors++;
        $display("FAIL simul_pop[%0d]: valid=%b ivl=%0d expected 1/%0d",
                 i, evt_valid, evt_interval, expv[i]);
      end
      step(0, 1, 0);
    end
  endtask

  task automatic test_saturation_clr;
    apply_reset();
    step(0, 0, 1);
    repeat (300) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    checks++;
    if (evt_valid !== 1'b1 || evt_interval !== 8'd255) begin
      errors++;
      $display("FAIL saturation: valid=%b ivl=%0d expected 1/255", evt_valid, evt_interval);
    end
    for (int p = 0; p < 4; p++) begin step(1, 0, 0); step(0, 0, 0); end
    checks++;
    if (overflow !== 1'b1 || total_cnt !== 16'd5) begin
      errors++;
      $display("FAIL sat_prefill: ovf=%b tot=%0d expected 1/5", overflow, total_cnt);
    end
    step(1, 0, 0);
    step(0, 0, 1);
    checks++;
    if (evt_valid !== 1'b0 || fifo_level !== '0 || total_cnt !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_rise: valid=%b lvl=%0d tot=%0d ovf=%b expected 0/0/0/0",
               evt_valid, fifo_level, total_cnt, overflow);
    end
    repeat (3) step(0, 0, 0);
    checks++;
    if (evt_valid !== 1'b0 || total_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_no_entry: valid=%b tot=%0d expected 0/0", evt_valid, total_cnt);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_iv;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
      exp_iv = (q.size() > 0) ? 8'(q[0]) : 8'd0;
      checks++;
      if (evt_valid !== (q.size() > 0) || evt_interval !== exp_iv ||
          fifo_level !== LW'(q.size()) || total_cnt !== 16'(m_total) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random[%0d]: valid=%b ivl=%0d lvl=%0d tot=%0d ovf=%b expected %b/%0d/%0d/%0d/%b",
                 i, evt_valid, evt_interval, fifo_level, total_cnt, overflow,
                 q.size() > 0, exp_iv, q.size(), m_total, m_ovf);
      end
`ifdef DETECT_EVENT_LOGGER_DROP_COUNT_EN
      checks++;
      if (drop_cnt !== 8'(m_drops)) begin
        errors++; $display("FAIL random_drop[%0d]: got %0d expected %0d", i, drop_cnt, m_drops);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_held_level();
    test_periodic();
    test_full();
    test_full_simultaneous();
    test_saturation_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
